// File: rtl/timer_ctrl.sv
// Control sequencer for the MM:SS countdown timer: key edges -> datapath pulses, SET/RUN/PAUSE/ALARM FSM.
// Optional feature: define ALARM_TIMEOUT_EN to auto-clear ALARM after ALARM_SEC seconds.
module timer_ctrl #(
  parameter logic [19:0] TICK_DIV    = 20'd152500,
  parameter logic [3:0]  REPEAT_DLY  = 4'd8,
  parameter logic [3:0]  REPEAT_RATE = 4'd2
`ifdef ALARM_TIMEOUT_EN
  , parameter logic [5:0] ALARM_SEC  = 6'd30
`endif
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       KEY_START,
  input  logic       KEY_STOP,
  input  logic       KEY_SEC,
  input  logic       KEY_MIN,
  input  logic       TIME_ZERO,
  output logic       START_PULSE,
  output logic       STOP_PULSE,
  output logic       ONE_SEC_PULSE,
  output logic       COUNT_UP_SEC_PULSE,
  output logic       COUNT_UP_MIN_PULSE,
  output logic       CLR_PULSE,
  output logic [1:0] STATE
);

  localparam logic [1:0] ST_SET   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic        key_start_d_r;
  logic        key_stop_d_r;
  logic [1:0]  set_key_d_r;
  logic        start_edge_s;
  logic        stop_edge_s;
  logic [1:0]  set_lvl_s;
  logic [1:0]  set_edge_s;
  logic        any_edge_s;
  logic [19:0] presc_r;
  logic [3:0]  tick_cnt_r;
  logic        tick_s;
  logic        one_sec_s;
  logic        enter_run_s;
  logic        stay_set_s;
  logic        start_s;
  logic        stop_s;
  logic        clr_s;
  logic [3:0]  rep_cnt_r [2];
  logic [1:0]  rep_phase_r;
  logic [1:0]  set_hit_s;
  logic [1:0]  set_pulse_s;
`ifdef ALARM_TIMEOUT_EN
  logic [5:0]  alarm_sec_r;
  logic        alarm_expire_s;
`endif

  // Index 0 is the seconds key, index 1 the minutes key.
  assign set_lvl_s    = {KEY_MIN, KEY_SEC};
  assign start_edge_s = KEY_START & ~key_start_d_r;
  assign stop_edge_s  = KEY_STOP & ~key_stop_d_r;
  assign set_edge_s   = set_lvl_s & ~set_key_d_r;
  assign any_edge_s   = start_edge_s | stop_edge_s | (|set_edge_s);
  assign tick_s       = (presc_r == (TICK_DIV - 20'd1));
  assign one_sec_s    = tick_s && (tick_cnt_r == 4'd15);
  assign enter_run_s  = (state_next_s == ST_RUN) && (state_r != ST_RUN);
  assign stay_set_s   = (state_r == ST_SET) && (state_next_s == ST_SET);
  assign STATE        = state_r;
`ifdef ALARM_TIMEOUT_EN
  assign alarm_expire_s = one_sec_s && (alarm_sec_r == (ALARM_SEC - 6'd1));
`endif

  // Next-state and command decode; a STOP edge always masks a simultaneous START edge.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    stop_s       = 1'b0;
    clr_s        = 1'b0;
    case (state_r)
      ST_SET: begin
        if (start_edge_s && !stop_edge_s && !TIME_ZERO) begin
          start_s      = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_SET;
        end
      end
      ST_RUN: begin
        if (stop_edge_s) begin
          stop_s       = 1'b1;
          state_next_s = ST_PAUSE;
        end else if (TIME_ZERO) begin
          state_next_s = ST_ALARM;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop_edge_s) begin
          clr_s        = 1'b1;
          state_next_s = ST_SET;
        end else if (start_edge_s) begin
          start_s      = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (any_edge_s) begin
          clr_s        = 1'b1;
          state_next_s = ST_SET;
`ifdef ALARM_TIMEOUT_EN
        end else if (alarm_expire_s) begin
          clr_s        = 1'b1;
          state_next_s = ST_SET;
`endif
        end else begin
          state_next_s = ST_ALARM;
        end
      end
      default: begin
        state_next_s = ST_SET;
      end
    endcase
  end

  // Repeat hit: first after REPEAT_DLY held ticks, then every REPEAT_RATE ticks.
  always_comb begin
    set_hit_s   = 2'b00;
    set_pulse_s = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (rep_phase_r[k]) begin
        set_hit_s[k] = set_lvl_s[k] && !set_edge_s[k] && tick_s &&
                       ((rep_cnt_r[k] + 4'd1) == REPEAT_RATE);
      end else begin
        set_hit_s[k] = set_lvl_s[k] && !set_edge_s[k] && tick_s &&
                       ((rep_cnt_r[k] + 4'd1) == REPEAT_DLY);
      end
      set_pulse_s[k] = (state_r == ST_SET) && (set_edge_s[k] || set_hit_s[k]);
    end
  end

  // State register and key history.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r       <= ST_SET;
      key_start_d_r <= 1'b0;
      key_stop_d_r  <= 1'b0;
      set_key_d_r   <= 2'b00;
    end else begin
      state_r       <= state_next_s;
      key_start_d_r <= KEY_START;
      key_stop_d_r  <= KEY_STOP;
      set_key_d_r   <= set_lvl_s;
    end
  end

  // 1/16 s prescaler and tick counter, realigned on every entry into RUN.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      presc_r    <= 20'd0;
      tick_cnt_r <= 4'd0;
    end else if (enter_run_s) begin
      presc_r    <= 20'd0;
      tick_cnt_r <= 4'd0;
    end else if (tick_s) begin
      presc_r    <= 20'd0;
      tick_cnt_r <= tick_cnt_r + 4'd1;
    end else begin
      presc_r    <= presc_r + 20'd1;
    end
  end

  // Per-key auto-repeat counters, live only while the key is held inside SET.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      rep_cnt_r[0] <= 4'd0;
      rep_cnt_r[1] <= 4'd0;
      rep_phase_r  <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!stay_set_s || !set_lvl_s[k] || set_edge_s[k]) begin
          rep_cnt_r[k]   <= 4'd0;
          rep_phase_r[k] <= 1'b0;
        end else if (set_hit_s[k]) begin
          rep_cnt_r[k]   <= 4'd0;
          rep_phase_r[k] <= 1'b1;
        end else if (tick_s) begin
          rep_cnt_r[k]   <= rep_cnt_r[k] + 4'd1;
        end
      end
    end
  end

`ifdef ALARM_TIMEOUT_EN
  // Seconds spent in ALARM; cleared whenever ALARM is not being held.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      alarm_sec_r <= 6'd0;
    end else if ((state_r != ST_ALARM) || (state_next_s != ST_ALARM)) begin
      alarm_sec_r <= 6'd0;
    end else if (one_sec_s) begin
      alarm_sec_r <= alarm_sec_r + 6'd1;
    end
  end
`endif

  // Registered one-cycle pulse outputs.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      START_PULSE        <= 1'b0;
      STOP_PULSE         <= 1'b0;
      ONE_SEC_PULSE      <= 1'b0;
      COUNT_UP_SEC_PULSE <= 1'b0;
      COUNT_UP_MIN_PULSE <= 1'b0;
      CLR_PULSE          <= 1'b0;
    end else begin
      START_PULSE        <= start_s;
      STOP_PULSE         <= stop_s;
      ONE_SEC_PULSE      <= (state_r == ST_RUN) && one_sec_s;
      COUNT_UP_SEC_PULSE <= set_pulse_s[0];
      COUNT_UP_MIN_PULSE <= set_pulse_s[1];
      CLR_PULSE          <= clr_s;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: directed scenarios plus random key traffic against a cycle-level reference model.
module tb_timer_ctrl;

  localparam int TD_I   = 4;
  localparam int DLY_I  = 8;
  localparam int RATE_I = 2;
`ifdef ALARM_TIMEOUT_EN
  localparam int ASEC_I = 2;
`endif

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       one_sec;
    logic       up_sec;
    logic       up_min;
    logic       clr;
    logic [1:0] state;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       KEY_START = 1'b0;
  logic       KEY_STOP = 1'b0;
  logic       KEY_SEC = 1'b0;
  logic       KEY_MIN = 1'b0;
  logic       TIME_ZERO = 1'b1;
  logic       START_PULSE;
  logic       STOP_PULSE;
  logic       ONE_SEC_PULSE;
  logic       COUNT_UP_SEC_PULSE;
  logic       COUNT_UP_MIN_PULSE;
  logic       CLR_PULSE;
  logic [1:0] STATE;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: 0=SET 1=RUN 2=PAUSE 3=ALARM.
  int         m_state;
  int         m_cyc;
  int         m_held [2];
  logic [3:0] m_kd;
`ifdef ALARM_TIMEOUT_EN
  int         m_asec;
`endif

  timer_ctrl #(
    .TICK_DIV   (20'd4),
    .REPEAT_DLY (4'd8),
    .REPEAT_RATE(4'd2)
`ifdef ALARM_TIMEOUT_EN
    , .ALARM_SEC(6'd2)
`endif
  ) dut (
    .CLK               (CLK),
    .RES               (RES),
    .KEY_START         (KEY_START),
    .KEY_STOP          (KEY_STOP),
    .KEY_SEC           (KEY_SEC),
    .KEY_MIN           (KEY_MIN),
    .TIME_ZERO         (TIME_ZERO),
    .START_PULSE       (START_PULSE),
    .STOP_PULSE        (STOP_PULSE),
    .ONE_SEC_PULSE     (ONE_SEC_PULSE),
    .COUNT_UP_SEC_PULSE(COUNT_UP_SEC_PULSE),
    .COUNT_UP_MIN_PULSE(COUNT_UP_MIN_PULSE),
    .CLR_PULSE         (CLR_PULSE),
    .STATE             (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_state   = 0;
    m_cyc     = 0;
    m_held[0] = 0;
    m_held[1] = 0;
    m_kd      = 4'b0000;
`ifdef ALARM_TIMEOUT_EN
    m_asec    = 0;
`endif
  endtask

  // keys = {min, sec, stop, start}; returns outputs expected after the next clock edge.
  task automatic model_step(input logic [3:0] keys, input logic tz, output exp_t e);
    logic [3:0] edges;
    logic       tick;
    logic       sec;
    logic [1:0] setp;
    int         nxt;
    edges = keys & ~m_kd;
    tick  = ((m_cyc + 1) % TD_I) == 0;
    sec   = ((m_cyc + 1) % (16 * TD_I)) == 0;
    e     = '0;
    setp  = 2'b00;
    nxt   = m_state;
    if (m_state == 0) begin
      if (edges[0] && !edges[1] && !tz) begin e.start = 1'b1; nxt = 1; end
    end else if (m_state == 1) begin
      if (edges[1]) begin e.stop = 1'b1; nxt = 2; end
      else if (tz) nxt = 3;
    end else if (m_state == 2) begin
      if (edges[1]) begin e.clr = 1'b1; nxt = 0; end
      else if (edges[0]) begin e.start = 1'b1; nxt = 1; end
    end else begin
      if (edges != 4'b0000) begin e.clr = 1'b1; nxt = 0; end
`ifdef ALARM_TIMEOUT_EN
      else if (sec && (m_asec + 1 == ASEC_I)) begin e.clr = 1'b1; nxt = 0; end
`endif
    end
`ifdef ALARM_TIMEOUT_EN
    if (m_state == 3 && nxt == 3) begin
      if (sec) m_asec = m_asec + 1;
    end else begin
      m_asec = 0;
    end
`endif
    for (int k = 0; k < 2; k++) begin
      if (m_state == 0) begin
        if (edges[2 + k]) begin
          setp[k]   = 1'b1;
          m_held[k] = 0;
        end else if (keys[2 + k]) begin
          if (tick) begin
            m_held[k] = m_held[k] + 1;
            if (m_held[k] == DLY_I || (m_held[k] > DLY_I && ((m_held[k] - DLY_I) % RATE_I) == 0))
              setp[k] = 1'b1;
          end
        end else begin
          m_held[k] = 0;
        end
      end
      if (m_state != 0 || nxt != 0) m_held[k] = 0;
    end
    e.up_sec  = setp[0];
    e.up_min  = setp[1];
    e.one_sec = (m_state == 1) && sec;
    e.state   = 2'(nxt);
    m_cyc     = (nxt == 1 && m_state != 1) ? 0 : m_cyc + 1;
    m_kd      = keys;
    m_state   = nxt;
  endtask

  task automatic drive(input logic [3:0] keys, input logic tz);
    exp_t e;
    @(negedge CLK);
    RES = 1'b0;
    {KEY_MIN, KEY_SEC, KEY_STOP, KEY_START} = keys;
    TIME_ZERO = tz;
    model_step(keys, tz, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] keys, input logic tz, input int n);
    for (int i = 0; i < n; i++) drive(keys, tz);
  endtask

  // Asynchronous reset must clear everything without waiting for a clock edge.
  task automatic apply_reset(input string name);
    exp_t a;
    @(negedge CLK);
    RES = 1'b1;
    #1;
    a = {START_PULSE, STOP_PULSE, ONE_SEC_PULSE, COUNT_UP_SEC_PULSE,
         COUNT_UP_MIN_PULSE, CLR_PULSE, STATE};
    vectors++;
    if (a !== 8'b0000_0000) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%b exp=00000000", name, $time, a);
    end
    model_reset();
  endtask

  // Monitor: pops one expected vector per clock edge once stimulus is flowing.
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {START_PULSE, STOP_PULSE, ONE_SEC_PULSE, COUNT_UP_SEC_PULSE,
             COUNT_UP_MIN_PULSE, CLR_PULSE, STATE};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got(start,stop,sec1,upS,upM,clr,st)=%b exp=%b", $time, a, e);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] k;
    logic       tz;
    model_reset();
    repeat (3) @(negedge CLK);
    apply_reset("reset_idle");

    // Start from SET and run long enough for two one-second pulses.
    hold(4'b0000, 1'b0, 2);
    drive(4'b0001, 1'b0);
    hold(4'b0000, 1'b0, 140);
    apply_reset("reset_mid_run");

    // Held seconds key with auto-repeat, then START ignored at 00:00, then both set keys.
    hold(4'b0000, 1'b1, 3);
    hold(4'b0100, 1'b1, 80);
    hold(4'b0000, 1'b1, 4);
    drive(4'b0001, 1'b1);
    hold(4'b0000, 1'b1, 3);
    hold(4'b1100, 1'b1, 50);
    hold(4'b0000, 1'b1, 3);

    // RUN -> PAUSE -> RUN -> PAUSE -> SET via double stop.
    drive(4'b0001, 1'b0);
    hold(4'b0000, 1'b0, 10);
    drive(4'b0010, 1'b0);
    hold(4'b0000, 1'b0, 5);
    drive(4'b0001, 1'b0);
    hold(4'b0000, 1'b0, 20);
    drive(4'b0010, 1'b0);
    hold(4'b0000, 1'b0, 3);
    drive(4'b0010, 1'b0);
    hold(4'b0000, 1'b0, 3);

    // Simultaneous start/stop in RUN, then RUN -> ALARM -> SET via minutes key.
    drive(4'b0001, 1'b0);
    hold(4'b0000, 1'b0, 6);
    drive(4'b0011, 1'b0);
    hold(4'b0000, 1'b0, 3);
    drive(4'b0001, 1'b0);
    hold(4'b0000, 1'b0, 4);
    hold(4'b0000, 1'b1, 150);
    drive(4'b1000, 1'b1);
    hold(4'b0000, 1'b1, 5);

    // Random key traffic with slowly changing levels.
    k  = 4'b0000;
    tz = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 39) == 0) k[b] = ~k[b];
      if (!tz && $urandom_range(0, 149) == 0) tz = 1'b1;
      else if (tz && $urandom_range(0, 19) == 0) tz = 1'b0;
      drive(k, tz);
    end
    hold(4'b0000, 1'b0, 2);

    repeat (2) @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control sequencer for the countdown timer datapath (the block holding the MM:SS down-counter and alarm tone).
- Converts four pre-debounced key levels into the datapath's one-cycle control pulses: start, stop, seconds/minutes set, and 1 s count enable.
- Runs a SET/RUN/PAUSE/ALARM state machine, generates the 1 s time base, auto-repeats held set keys, and clears the datapath via a pulse.

Parameters:
TICK_DIV, 20'd152500, CLK cycles per 1/16 s tick (legal range 2..2^20-1).
REPEAT_DLY, 4'd8, ticks a set key is held before auto-repeat starts.
REPEAT_RATE, 4'd2, ticks between auto-repeat pulses.
ALARM_SEC, 6'd30, alarm duration in seconds before auto-clear (used only with the optional feature).

Ports:
CLK  input  1  system clock, rising edge.
RES  input  1  asynchronous, active-high reset.
KEY_START  input  1  debounced start key level.
KEY_STOP  input  1  debounced stop key level.
KEY_SEC  input  1  debounced seconds-set key level.
KEY_MIN  input  1  debounced minutes-set key level.
TIME_ZERO  input  1  datapath time is 00:00 (combinational from counter outputs).
START_PULSE  output  1  1-cycle start command to datapath.
STOP_PULSE  output  1  1-cycle stop command to datapath.
ONE_SEC_PULSE  output  1  1-cycle count-down enable, once per second in RUN.
COUNT_UP_SEC_PULSE  output  1  1-cycle seconds set pulse.
COUNT_UP_MIN_PULSE  output  1  1-cycle minutes set pulse.
CLR_PULSE  output  1  1-cycle datapath clear; top level ORs it into the datapath reset.
STATE  output  2  0=SET, 1=RUN, 2=PAUSE, 3=ALARM.

Behaviour:
- Reset: all pulse outputs 0, STATE=SET, all counters 0, key history registers 0. Reset is honoured mid-operation, with outputs forced immediately.
- Edge detect: each key is registered once. The edge condition is KEY & ~KEY_d. All outputs are registered and assert on the CLK edge after the edge is detected (1-cycle latency). Every pulse is exactly 1 cycle wide.
- Tick prescaler: free-running 0..TICK_DIV-1 and wraps to 0. TICK is high when the count equals TICK_DIV-1. The prescaler and the 4-bit tick counter clear on any transition into RUN.
- ONE_SEC_PULSE: asserted only in RUN, on every 16th TICK. The first pulse comes exactly 16*TICK_DIV cycles after entering RUN.
- SET state:
  - START edge with TIME_ZERO=0: START_PULSE, go to RUN.
  - START edge with TIME_ZERO=1: ignored.
  - KEY_SEC / KEY_MIN: an edge gives one pulse. While the key stays held, the first repeat comes REPEAT_DLY ticks after the edge, then one every REPEAT_RATE ticks. Releasing the key clears that key's repeat counter.
  - SEC and MIN are independent; both pulses may assert in the same cycle.
- RUN state:
  - STOP edge: STOP_PULSE, go to PAUSE.
  - Otherwise TIME_ZERO=1 sampled in RUN: go to ALARM, with no pulse.
  - Set keys are ignored.
- PAUSE state:
  - START edge: START_PULSE, go to RUN (resume).
  - STOP edge: CLR_PULSE, go to SET.
- ALARM state: a rising edge on any key gives CLR_PULSE and a return to SET.
- Simultaneous START and STOP edges: STOP wins; START is discarded.
- Mutual exclusion: START_PULSE and STOP_PULSE never assert in the same cycle. CLR_PULSE never coincides with START_PULSE or STOP_PULSE.
- Set pulses are never generated outside SET. Repeat counters clear on leaving SET.

Optional Feature:
ALARM_TIMEOUT_EN
- Defined: a 6-bit seconds counter runs in ALARM, clocked by 16-tick seconds. At ALARM_SEC it issues CLR_PULSE and returns to SET. A key edge in the same cycle produces a single CLR_PULSE only.
- Undefined: ALARM persists until a key edge. The counter logic is absent.

Test Plan (TICK_DIV=4, REPEAT_DLY=8, REPEAT_RATE=2, ALARM_SEC=2):
1. Reset with keys low -> all outputs 0, STATE=0. Assert RES mid-RUN -> STATE=0 in the same cycle, outputs 0.
2. SET, TIME_ZERO=0, KEY_START rises -> START_PULSE 1 cycle, STATE=1. ONE_SEC_PULSE at +64 cycles, then every 64 cycles.
3. SET, KEY_SEC held 80 cycles -> COUNT_UP_SEC_PULSE at edge+1, edge+32, edge+40, edge+48, ... (5 pulses by cycle 64). KEY_START rise while TIME_ZERO=1 -> no pulse, STATE stays 0.
4. RUN, KEY_STOP rise -> STOP_PULSE, STATE=2. KEY_START rise -> START_PULSE, STATE=1. STOP, then a second STOP -> CLR_PULSE, STATE=0.
5. RUN, KEY_START and KEY_STOP rise in the same cycle -> only STOP_PULSE. RUN with TIME_ZERO=1 -> STATE=3, no pulses.
6. ALARM with ALARM_TIMEOUT_EN defined, no keys -> CLR_PULSE after 128 cycles, STATE=0. Undefined -> stays in ALARM until a KEY_MIN rise, then CLR_PULSE.
